// File: rtl/mem_lsu_pkg.sv
// rtl/mem_lsu_pkg.sv - shared types for the MEM load/store stage
// Purpose: EXE->MEM and MEM->WB payload structs, write-back source select,
//          LSU FSM state encoding and byte-enable constants.
package mem_lsu_pkg;

  typedef enum logic [1:0] {
    WB_SRC_ALU = 2'd0,
    WB_SRC_MEM = 2'd1,
    WB_SRC_PC  = 2'd2
  } result_src_e;

  typedef struct packed {
    logic        register_write;
    logic        branch_taken;
    result_src_e result_src;
    logic        mem_store;
    logic        mem_load;
  } exe_ctrl_t;

  typedef struct packed {
    exe_ctrl_t   ctrl;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [4:0]  rd;
    logic [31:0] pc_inc;
    logic [31:0] branch_target;
  } exe_mem_inf_t;

  typedef struct packed {
    logic        register_write;
    result_src_e result_src;
  } wb_ctrl_t;

  typedef struct packed {
    wb_ctrl_t    ctrl;
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [4:0]  rd;
    logic [31:0] pc_inc;
  } mem_wb_inf_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } lsu_state_e;

  localparam logic [3:0] BE_WORD = 4'hF;
  localparam logic [3:0] BE_NONE = 4'h0;

  function automatic logic is_access(input exe_ctrl_t c);
    return c.mem_load | c.mem_store;
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// rtl/mem_lsu_if.sv - data-memory req/ack bus between the LSU and memory
// Purpose: groups the dmem_* request/response signals.
// Ports (modport master = LSU side):
//   out dmem_req, dmem_we, dmem_addr[31:0], dmem_wdata[31:0], dmem_be[3:0]
//   in  dmem_ack, dmem_rdata[31:0]
interface mem_lsu_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_lsu_watchdog.sv
// rtl/mem_lsu_watchdog.sv - wait-state watchdog counter for the LSU
// Purpose: counts enabled cycles; expire is raised combinationally while
//          enabled with the count at TIMEOUT_CYCLES-1, and the count then restarts.
// Ports: clk, rst (sync, active-high), clear (force count to 0),
//        enable (count this cycle), expire (abort request).
module mem_lsu_watchdog #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [15:0] count;

  assign expire = enable && (count == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || clear || expire) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - MEM pipeline stage: word load/store over req/ack bus
// Purpose: issues data-memory accesses from the EXE->MEM payload, stalls the
//          core while an access is outstanding, aborts unacknowledged accesses
//          via a watchdog, and registers results into the MEM->WB payload.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   exe_mem_inf         EXE->MEM payload (in)
//   mem_wb_inf          MEM->WB payload, registered (out)
//   mem_alu_result      forwarding value (out, comb)
//   branch_redirect     branch taken in MEM (out, comb)
//   branch_target       redirect target (out, comb)
//   mem_stall           freeze IF..EXE and the EXE->MEM register (out)
//   dmem                data-memory bus, mem_lsu_if.master
//   bus_err             one-cycle pulse after a watchdog abort (out)
//   misalign            one-cycle pulse after a misaligned access
//                       (only when MEM_MISALIGN_TRAP_EN is defined)
// Configuration: MEM_MISALIGN_TRAP_EN enables the misaligned-access trap;
//                otherwise the low address bits are dropped.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  exe_mem_inf_t  exe_mem_inf,
  output mem_wb_inf_t   mem_wb_inf,
  output logic [31:0]   mem_alu_result,
  output logic          branch_redirect,
  output logic [31:0]   branch_target,
  output logic          mem_stall,
  mem_lsu_if.master     dmem,
  output logic          bus_err
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic          misalign
`endif
);

  lsu_state_e state, state_nxt;
  logic       access;
  logic       misalign_hit;
  logic       access_ok;
  logic       req;
  logic       done;
  logic       abort;
  logic       wd_enable;
  logic       wd_clear;
  logic       wd_expire;

  assign access = is_access(exe_mem_inf.ctrl);

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_hit = access && (exe_mem_inf.alu_result[1:0] != 2'b00);
`else
  assign misalign_hit = 1'b0;
`endif

  assign access_ok = access && !misalign_hit;

  assign mem_alu_result  = exe_mem_inf.alu_result;
  assign branch_redirect = exe_mem_inf.ctrl.branch_taken;
  assign branch_target   = exe_mem_inf.branch_target;

  // Address/data come straight from the EXE->MEM register, which the core
  // freezes while mem_stall is high, so they stay stable across WAIT.
  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = exe_mem_inf.ctrl.mem_store;
  assign dmem.dmem_addr  = {exe_mem_inf.alu_result[31:2], 2'b00};
  assign dmem.dmem_wdata = exe_mem_inf.write_data;
  assign dmem.dmem_be    = exe_mem_inf.ctrl.mem_store ? BE_WORD : BE_NONE;

  // Only WAIT cycles without an ack are counted; the IDLE issue cycle clears.
  assign wd_enable = (state == WAIT) && !dmem.dmem_ack;
  assign wd_clear  = (state != WAIT);

  mem_lsu_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expire (wd_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    mem_stall = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (access_ok) begin
          req = 1'b1;
          if (dmem.dmem_ack) begin
            done = 1'b1;
          end else begin
            mem_stall = 1'b1;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        // An ack in the expiry cycle still completes the access normally.
        if (dmem.dmem_ack) begin
          req       = 1'b1;
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (wd_expire) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else begin
          req       = 1'b1;
          mem_stall = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Reset drops the request in the same cycle and discards the access.
    if (rst) begin
      state_nxt = IDLE;
      req       = 1'b0;
      mem_stall = 1'b0;
      done      = 1'b0;
      abort     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_wb_inf <= '0;
      bus_err    <= 1'b0;
    end else begin
      // Stalled cycles become bubbles; aborted or trapped accesses never write back.
      mem_wb_inf.ctrl.register_write <= exe_mem_inf.ctrl.register_write &&
                                        !mem_stall && !abort && !misalign_hit;
      mem_wb_inf.ctrl.result_src     <= exe_mem_inf.ctrl.result_src;
      mem_wb_inf.alu_result          <= exe_mem_inf.alu_result;
      mem_wb_inf.rd                  <= exe_mem_inf.rd;
      mem_wb_inf.pc_inc              <= exe_mem_inf.pc_inc;
      if (done && exe_mem_inf.ctrl.mem_load) begin
        mem_wb_inf.read_data <= dmem.dmem_rdata;
      end
      bus_err <= abort;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign <= 1'b0;
    end else begin
      misalign <= misalign_hit;
    end
  end
`endif

endmodule
